// File: rtl/burst_stream_checker.sv
// Checks preamble/PRBS-31 bursts on an AXI-stream slave and keeps saturating event counters.
// state    | meaning
// IDLE     | between bursts; a preamble word opens a burst, anything else is stray
// PREAMBLE | counting preamble words; the first non-preamble word seeds the LFSR
// CHECK    | comparing each data word against the PRBS prediction
module burst_stream_checker (
  input  logic        tx_axis_usrclk,
  input  logic        reset_in,
  input  logic [31:0] s_axis_TDATA,
  input  logic        s_axis_TVALID,
  output logic        s_axis_TREADY,
  input  logic        s_axis_TLAST,
  input  logic [3:0]  s_axis_TKEEP,
  input  logic        s_axis_TUSER,
  input  logic [31:0] preamble,
  input  logic [31:0] preamble_length,
  input  logic [31:0] burst_length,
  output logic [31:0] burst_count,
  output logic [31:0] data_error_count,
  output logic [31:0] preamble_error_count,
  output logic [31:0] length_error_count,
  output logic [31:0] keep_error_count,
  output logic [31:0] stray_count,
  output logic [31:0] last_burst_words,
  output logic        prbs_locked
);

  typedef enum logic [1:0] {ST_IDLE, ST_PREAMBLE, ST_CHECK} state_t;

  state_t      state_q;
  logic        ready_q, locked_q;
  logic [31:0] word_cnt_q, pre_cnt_q, pre_len_q, burst_len_q;
  logic [30:0] lfsr_q;
  logic [31:0] burst_cnt_q, data_err_q, pre_err_q, len_err_q, keep_err_q, stray_q, last_words_q;

  logic        xfer, is_pre, keep_bad, closes;
  logic [31:0] word_cnt_d, pre_cnt_d, total_d, pre_final_d, len_ref, pre_ref;
  logic [31:0] pred_word;
  logic [30:0] pred_state;
  logic        unused_tuser;

  assign unused_tuser = s_axis_TUSER;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // 32 Fibonacci steps of x^31+x^28+1; first generated bit lands in bit 31.
  function automatic logic [62:0] prbs_adv(input logic [30:0] s);
    logic [30:0] st;
    logic [31:0] w;
    logic        nb;
    st = s;
    w  = '0;
    for (int i = 0; i < 32; i++) begin
      nb        = st[30] ^ st[27];
      st        = {st[29:0], nb};
      w[31 - i] = nb;
    end
    return {w, st};
  endfunction

  always_comb begin
    {pred_word, pred_state} = prbs_adv(lfsr_q);
    xfer        = s_axis_TVALID & ready_q;
    is_pre      = (s_axis_TDATA == preamble);
    keep_bad    = (s_axis_TKEEP != 4'hF);
    word_cnt_d  = sat_inc(word_cnt_q);
    pre_cnt_d   = sat_inc(pre_cnt_q);
    total_d     = (state_q == ST_IDLE) ? 32'd1 : word_cnt_d;
    pre_final_d = (state_q == ST_IDLE) ? 32'd1 :
                  (state_q == ST_PREAMBLE && is_pre) ? pre_cnt_d : pre_cnt_q;
    len_ref     = (state_q == ST_IDLE) ? burst_length : burst_len_q;
    pre_ref     = (state_q == ST_IDLE) ? preamble_length : pre_len_q;
    closes      = s_axis_TLAST && ((state_q != ST_IDLE) || is_pre);
  end

  always_ff @(posedge tx_axis_usrclk) begin
    if (reset_in) begin
      state_q      <= ST_IDLE;
      ready_q      <= 1'b0;
      locked_q     <= 1'b0;
      word_cnt_q   <= '0;
      pre_cnt_q    <= '0;
      pre_len_q    <= '0;
      burst_len_q  <= '0;
      lfsr_q       <= '0;
      burst_cnt_q  <= '0;
      data_err_q   <= '0;
      pre_err_q    <= '0;
      len_err_q    <= '0;
      keep_err_q   <= '0;
      stray_q      <= '0;
      last_words_q <= '0;
    end else begin
      ready_q <= 1'b1;
      if (xfer) begin
        if (keep_bad) keep_err_q <= sat_inc(keep_err_q);
        case (state_q)
          ST_IDLE: begin
            if (is_pre) begin
              pre_len_q   <= preamble_length;
              burst_len_q <= burst_length;
              word_cnt_q  <= 32'd1;
              pre_cnt_q   <= 32'd1;
              state_q     <= ST_PREAMBLE;
            end else begin
              stray_q <= sat_inc(stray_q);
            end
          end
          ST_PREAMBLE: begin
            word_cnt_q <= word_cnt_d;
            if (is_pre) begin
              pre_cnt_q <= pre_cnt_d;
            end else begin
              lfsr_q   <= s_axis_TDATA[30:0];
              locked_q <= 1'b1;
              state_q  <= ST_CHECK;
            end
          end
          ST_CHECK: begin
            word_cnt_q <= word_cnt_d;
            lfsr_q     <= pred_state;
            if (s_axis_TDATA != pred_word) begin
              data_err_q <= sat_inc(data_err_q);
              locked_q   <= 1'b0;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
        // Burst close overrides the state chosen above.
        if (closes) begin
          burst_cnt_q  <= sat_inc(burst_cnt_q);
          last_words_q <= total_d;
          if (total_d != len_ref) len_err_q <= sat_inc(len_err_q);
          if (pre_final_d != pre_ref) pre_err_q <= sat_inc(pre_err_q);
          state_q <= ST_IDLE;
        end
      end
    end
  end

  assign s_axis_TREADY        = ready_q;
  assign prbs_locked          = locked_q;
  assign burst_count          = burst_cnt_q;
  assign data_error_count     = data_err_q;
  assign preamble_error_count = pre_err_q;
  assign length_error_count   = len_err_q;
  assign keep_error_count     = keep_err_q;
  assign stray_count          = stray_q;
  assign last_burst_words     = last_words_q;

endmodule

// File: doc/burst_stream_checker.md
BURST_STREAM_CHECKER -- requirements
Module: burst_stream_checker

Interface
REQ-001 Parameter: none; all configuration is by input ports.
REQ-002 tx_axis_usrclk  in  1  sole clock; all logic on the rising edge.
REQ-003 reset_in  in  1  reset, synchronous, active-high.
REQ-004 s_axis_TDATA  in  32  burst word: preamble or PRBS data.
REQ-005 s_axis_TVALID  in  1  word valid.
REQ-006 s_axis_TREADY  out  1  checker ready.
REQ-007 s_axis_TLAST  in  1  final word of burst.
REQ-008 s_axis_TKEEP  in  4  byte enables; 4'hF expected.
REQ-009 s_axis_TUSER  in  1  ignored.
REQ-010 preamble  in  32  expected preamble word, e.g. 32'h05560556.
REQ-011 preamble_length  in  32  expected preamble words per burst.
REQ-012 burst_length  in  32  expected total words per burst, preamble included.
REQ-013 burst_count  out  32  bursts completed (TLAST seen).
REQ-014 data_error_count  out  32  data words mismatching PRBS prediction.
REQ-015 preamble_error_count  out  32  bursts whose preamble word count != preamble_length.
REQ-016 length_error_count  out  32  bursts whose total word count != burst_length.
REQ-017 keep_error_count  out  32  accepted words with TKEEP != 4'hF.
REQ-018 stray_count  out  32  words accepted in IDLE that are not the preamble.
REQ-019 last_burst_words  out  32  total word count of the most recent burst.
REQ-020 prbs_locked  out  1  high while the current burst's data words all match.

Function
REQ-021 Transfer = TVALID & TREADY on a clock edge; only transfers change state or counters.
REQ-022 s_axis_TREADY is 0 during reset and 1 on every cycle after reset deasserts.
REQ-023 FSM states: IDLE, PREAMBLE, CHECK.
REQ-024 IDLE: on a transfer with TDATA == preamble, latch preamble_length and burst_length, set word_cnt=1 and pre_cnt=1, go to PREAMBLE; on any other transfer, stray_count++ and stay in IDLE.
REQ-025 PREAMBLE: on a transfer with TDATA == preamble, pre_cnt++; on any other transfer, treat the word as the seed, set the LFSR state to TDATA[30:0], set prbs_locked=1, and go to CHECK.
REQ-026 The seed word is not error-checked; word_cnt increments on every transfer inside a burst.
REQ-027 PRBS: PRBS-31 (x^31+x^28+1), Fibonacci form, 31-bit state s; each step computes new bit = s[30]^s[27], shifts it into s[0], and outputs it; a word is 32 steps, first output in bit 31.
REQ-028 CHECK: on each transfer, compare TDATA against the predicted next word; on mismatch, data_error_count++ and prbs_locked=0; the LFSR always advances from the predicted state, never re-seeds mid-burst.
REQ-029 On a transfer with TLAST=1 in any burst state: burst_count++; last_burst_words=word_cnt including this word; if the total != latched burst_length, length_error_count++; if pre_cnt != latched preamble_length, preamble_error_count++; then go to IDLE.
REQ-030 TLAST on the first preamble word in IDLE closes a one-word burst immediately with pre_cnt=1 and word_cnt=1; all REQ-029 checks apply.
REQ-031 TLAST on the seed word closes the burst; the word counts as data and no data check is made.
REQ-032 TKEEP != 4'hF on any transfer, in any state, increments keep_error_count; the word is still processed normally.
REQ-033 All counters saturate at 32'hFFFFFFFF; word_cnt and pre_cnt also saturate.
REQ-034 Outputs are registered and reflect a transfer on the edge after it, i.e. one-cycle latency.
REQ-035 Config inputs changing mid-burst have no effect until the next burst starts.
REQ-036 Gaps with TVALID=0 hold all state; there is no timeout.

Reset
REQ-037 While reset_in=1: state=IDLE; all counters, last_burst_words, word_cnt, pre_cnt and LFSR=0; prbs_locked=0; TREADY=0.
REQ-038 Reset mid-burst discards the partial burst with no counter update; the next burst is checked from scratch.

Verification
REQ-039 Ideal burst (preamble=32'h05560556, preamble_length=4, burst_length=20; 4 preambles + seed + 15 correct PRBS words, TLAST on word 20) -> burst_count=1, last_burst_words=20, all error counts 0, prbs_locked=1.
REQ-040 Same burst with bit 0 flipped in data word 10 -> data_error_count=1, prbs_locked=0; the following words still match with no further errors.
REQ-041 Burst of 3 preambles + 16 data words -> preamble_error_count=1, length_error_count=1, last_burst_words=19.
REQ-042 Two non-preamble words before a burst plus random TVALID gaps -> stray_count=2; the burst checks clean.
REQ-043 TKEEP=4'h7 on one data word -> keep_error_count=1, data_error_count=0.
REQ-044 reset_in pulsed after 8 words of a burst, then a full clean burst -> all counters 0 after reset; burst_count=1 with 0 errors after the clean burst.
